div_scheduler: RTL and testbench

- Arbitrates two requesters onto one shared single-precision Goldschmidt divider.
- Registers operands onto the divider inputs and tracks each in-flight operation through the divider's fixed latency with a tag shift register.
- Routes each quotient back to the requester that issued it, with a divide-by-zero flag.
- Sits between the client blocks and the divider instance; the divider has no handshake of its own.

---
 rtl/div_scheduler.sv | 124 ++++++++++++
 tb/tb_div_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// Two-requester round-robin front end for a shared, handshake-free divider.
// Registers operands to the divider and returns each quotient to its issuer.
module div_scheduler #(
    parameter int unsigned DIV_LATENCY = 8,
    parameter int unsigned ISSUE_GAP   = 0
) (
    input  logic        clk,
    input  logic        clear_b,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_n,
    input  logic [31:0] req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_n,
    input  logic [31:0] req1_d,
    output logic [31:0] div_n,
    output logic [31:0] div_d,
    input  logic [31:0] div_q,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_q,
    output logic        rsp0_dz,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_q,
    output logic        rsp1_dz,
    output logic        busy
);

    localparam int unsigned DEPTH = DIV_LATENCY + 1;
    localparam int unsigned OUT   = DIV_LATENCY;
    localparam int unsigned GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    typedef struct packed {
        logic valid;
        logic tag;
        logic dz;
    } trk_t;

    trk_t             trk [DEPTH];
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             slot_free;
    logic             sel0;
    logic             sel1;
    logic             issue;
    logic             win_dz;
    logic [31:0]      win_n;
    logic [31:0]      win_d;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        slot_free  = (gap_cnt == '0);
        sel1       = req1_valid & (~req0_valid | ~last_grant);
        sel0       = req0_valid & ~sel1;
        req0_ready = slot_free & sel0;
        req1_ready = slot_free & sel1;
        issue      = req0_ready | req1_ready;
        win_n      = sel1 ? req1_n : req0_n;
        win_d      = sel1 ? req1_d : req0_d;
        win_dz     = (win_d[30:0] == 31'd0);
    end

    always_comb begin
        busy = rsp0_valid | rsp1_valid;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy = busy | trk[i].valid;
        end
    end

    // Operand registers, grant history and issue spacing.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            div_n      <= '0;
            div_d      <= '0;
            last_grant <= 1'b1;
            gap_cnt    <= '0;
        end else if (issue) begin
            div_n      <= win_n;
            div_d      <= win_d;
            last_grant <= sel1;
            gap_cnt    <= GAP_W'(ISSUE_GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt    <= gap_cnt - GAP_W'(1);
        end
    end

    // Tag pipeline aligned so its last stage coincides with the matching div_q.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0] <= '{valid: issue, tag: sel1, dz: win_dz};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    // Response capture; quotient and flag hold between pulses.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            rsp0_valid <= 1'b0;
            rsp0_q     <= '0;
            rsp0_dz    <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_q     <= '0;
            rsp1_dz    <= 1'b0;
        end else begin
            rsp0_valid <= trk[OUT].valid & ~trk[OUT].tag;
            rsp1_valid <= trk[OUT].valid & trk[OUT].tag;
            if (trk[OUT].valid & ~trk[OUT].tag) begin
                rsp0_q  <= div_q;
                rsp0_dz <= trk[OUT].dz;
            end
            if (trk[OUT].valid & trk[OUT].tag) begin
                rsp1_q  <= div_q;
                rsp1_dz <= trk[OUT].dz;
            end
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler using an XOR divider stub delayed by the divider latency.
module tb_div_scheduler;

    localparam int unsigned LAT = 8;

    logic clk = 1'b0;
    logic clear_b = 1'b0;
    always #5 clk = ~clk;

    logic        a_r0v, a_r0r, a_r1v, a_r1r;
    logic [31:0] a_r0n, a_r0d, a_r1n, a_r1d;
    logic [31:0] a_dn, a_dd, a_dq;
    logic        a_s0v, a_s0dz, a_s1v, a_s1dz, a_busy;
    logic [31:0] a_s0q, a_s1q;

    logic        g_r0v, g_r0r, g_r1v, g_r1r;
    logic [31:0] g_r0n, g_r0d, g_r1n, g_r1d;
    logic [31:0] g_dn, g_dd, g_dq;
    logic        g_s0v, g_s0dz, g_s1v, g_s1dz, g_busy;
    logic [31:0] g_s0q, g_s1q;

    div_scheduler #(.DIV_LATENCY(LAT), .ISSUE_GAP(0)) u_dut (
        .clk(clk), .clear_b(clear_b),
        .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_n(a_r0n), .req0_d(a_r0d),
        .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_n(a_r1n), .req1_d(a_r1d),
        .div_n(a_dn), .div_d(a_dd), .div_q(a_dq),
        .rsp0_valid(a_s0v), .rsp0_q(a_s0q), .rsp0_dz(a_s0dz),
        .rsp1_valid(a_s1v), .rsp1_q(a_s1q), .rsp1_dz(a_s1dz),
        .busy(a_busy)
    );

    div_scheduler #(.DIV_LATENCY(LAT), .ISSUE_GAP(8)) u_gap (
        .clk(clk), .clear_b(clear_b),
        .req0_valid(g_r0v), .req0_ready(g_r0r), .req0_n(g_r0n), .req0_d(g_r0d),
        .req1_valid(g_r1v), .req1_ready(g_r1r), .req1_n(g_r1n), .req1_d(g_r1d),
        .div_n(g_dn), .div_d(g_dd), .div_q(g_dq),
        .rsp0_valid(g_s0v), .rsp0_q(g_s0q), .rsp0_dz(g_s0dz),
        .rsp1_valid(g_s1v), .rsp1_q(g_s1q), .rsp1_dz(g_s1dz),
        .busy(g_busy)
    );

    // Divider stubs: div_q = div_n ^ div_d, LAT cycles after the operands change.
    logic [31:0] a_pipe [LAT];
    logic [31:0] g_pipe [LAT];
    always @(posedge clk) begin
        a_pipe[0] <= a_dn ^ a_dd;
        g_pipe[0] <= g_dn ^ g_dd;
        for (int i = 1; i < LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            g_pipe[i] <= g_pipe[i-1];
        end
    end
    assign a_dq = a_pipe[LAT-1];
    assign g_dq = g_pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Counts any response pulse while the reset test is armed.
    logic mon_en = 1'b0;
    int   rsp_seen = 0;
    always @(negedge clk) begin
        if (mon_en && (a_s0v || a_s1v)) rsp_seen++;
    end

    typedef struct {
        logic        req;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] q;
        logic        dz;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v);
        int  early;
        logic rv, ov;
        early = 0;
        @(posedge clk); #1;
        if (v.req) begin a_r1v = 1'b1; a_r1n = v.n; a_r1d = v.d; end
        else       begin a_r0v = 1'b1; a_r0n = v.n; a_r0d = v.d; end
        @(negedge clk);
        chk("ready_sel",   v.req ? a_r1r : a_r0r, 32'd1);
        chk("ready_other", v.req ? a_r0r : a_r1r, 32'd0);
        @(posedge clk); #1;
        a_r0v = 1'b0; a_r1v = 1'b0;
        @(negedge clk);
        chk("div_n", a_dn, v.n);
        chk("div_d", a_dd, v.d);
        for (int k = 2; k <= 11; k++) begin
            @(negedge clk);
            rv = v.req ? a_s1v : a_s0v;
            ov = v.req ? a_s0v : a_s1v;
            if (k == 10) begin
                chk("rsp_valid", rv, 32'd1);
                chk("rsp_q",  v.req ? a_s1q : a_s0q, v.q);
                chk("rsp_dz", v.req ? a_s1dz : a_s0dz, v.dz);
                if (ov) early++;
            end else begin
                if (rv || ov) early++;
            end
            if (k == 11) chk("busy_idle", a_busy, 32'd0);
        end
        chk("stray_rsp", early, 32'd0);
    endtask

    initial begin
        int g0, g1, alt, prev, g, nis;
        int icyc [8];

        a_r0v = 0; a_r1v = 0; a_r0n = 0; a_r0d = 0; a_r1n = 0; a_r1d = 0;
        g_r0v = 0; g_r1v = 0; g_r0n = 0; g_r0d = 0; g_r1n = 0; g_r1d = 0;

        vecs[0] = '{req: 1'b0, n: 32'h41280000, d: 32'h40100000, q: 32'h01380000, dz: 1'b0};
        vecs[1] = '{req: 1'b1, n: 32'h3F800000, d: 32'h80000000, q: 32'hBF800000, dz: 1'b1};
        vecs[2] = '{req: 1'b1, n: 32'h40000000, d: 32'h3F800000, q: 32'h7F800000, dz: 1'b0};
        vecs[3] = '{req: 1'b0, n: 32'h7FC00000, d: 32'h00000000, q: 32'h7FC00000, dz: 1'b1};
        vecs[4] = '{req: 1'b0, n: 32'h3F800000, d: 32'h00000001, q: 32'h3F800001, dz: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", a_busy, 32'd0);
        chk("rst_div_n", a_dn, 32'd0);
        chk("rst_div_d", a_dd, 32'd0);
        chk("rst_rsp0_v", a_s0v, 32'd0);
        chk("rst_rsp1_q", a_s1q, 32'd0);
        @(posedge clk); #1 clear_b = 1'b1;

        // Contention from reset: req0 first, then req1
        @(posedge clk); #1;
        a_r0v = 1; a_r0n = 32'h453B8000; a_r0d = 32'h41A40000;
        a_r1v = 1; a_r1n = 32'h3E712EC7; a_r1d = 32'hBEC4FB55;
        @(negedge clk);
        chk("cont_r0_first", a_r0r, 32'd1);
        chk("cont_r1_wait", a_r1r, 32'd0);
        @(posedge clk); #1 a_r0v = 0;
        @(negedge clk);
        chk("cont_r1_second", a_r1r, 32'd1);
        @(posedge clk); #1 a_r1v = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("cont_rsp0_v", a_s0v, 32'd1);
        chk("cont_rsp0_q", a_s0q, 32'h049F8000);
        chk("cont_rsp1_v_early", a_s1v, 32'd0);
        @(negedge clk);
        chk("cont_rsp1_v", a_s1v, 32'd1);
        chk("cont_rsp1_q", a_s1q, 32'h80B5D592);
        chk("cont_rsp0_v_after", a_s0v, 32'd0);
        repeat (3) @(posedge clk);

        // Directed single-op vectors
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Fairness: both held valid for 8 cycles
        @(posedge clk); #1;
        a_r0v = 1; a_r0n = 32'h40400000; a_r0d = 32'h3F800000;
        a_r1v = 1; a_r1n = 32'h40800000; a_r1d = 32'h40000000;
        g0 = 0; g1 = 0; alt = 0; prev = 2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = a_r1r ? 1 : (a_r0r ? 0 : 2);
            if (g == 0) g0++;
            if (g == 1) g1++;
            if (i > 0 && g != prev && g != 2) alt++;
            prev = g;
        end
        @(posedge clk); #1 a_r0v = 0; a_r1v = 0;
        chk("fair_cnt0", g0, 32'd4);
        chk("fair_cnt1", g1, 32'd4);
        chk("fair_alternate", alt, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("fair_drained", a_busy, 32'd0);

        // ISSUE_GAP=8: issues 9 cycles apart
        @(posedge clk); #1;
        g_r0v = 1; g_r0n = 32'h41000000; g_r0d = 32'h40000000;
        nis = 0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (g_r0r) begin
                if (nis < 8) icyc[nis] = c;
                nis++;
            end
        end
        @(posedge clk); #1 g_r0v = 0;
        chk("gap_issue_cnt", nis, 32'd4);
        for (int i = 0; i < 4; i++) chk("gap_issue_cycle", icyc[i], 32'(9 * i));

        // Reset mid-flight
        repeat (12) @(posedge clk);
        #1;
        mon_en = 1'b1;
        a_r0v = 1; a_r0n = 32'h12345678; a_r0d = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1 a_r0v = 0;
        @(negedge clk);
        chk("mid_busy", a_busy, 32'd1);
        repeat (3) @(posedge clk);
        #1 clear_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear_b = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("mid_no_rsp", rsp_seen, 32'd0);
        chk("mid_busy_clr", a_busy, 32'd0);
        chk("mid_div_n", a_dn, 32'd0);
        chk("mid_div_d", a_dd, 32'd0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        a_r0v = 1; a_r1v = 1;
        @(negedge clk);
        chk("post_rst_r0", a_r0r, 32'd1);
        chk("post_rst_r1", a_r1r, 32'd0);
        @(posedge clk); #1 a_r0v = 0; a_r1v = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
